// File: rtl/seg7_scan_capture.sv
// Receive side of a multiplexed 4-digit 7-segment scan: settles each digit dwell, decodes it and
// reassembles the displayed 16-bit value. Optional frame counter: define SEG7_CAPTURE_FRAME_CNT_EN.
module seg7_scan_capture #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter bit SEG_INV        = 1'b0
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [3:0]  AN,
    input  logic [6:0]  DS7,
    output logic [15:0] VALUE,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        an_err
`ifdef SEG7_CAPTURE_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int STAB_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } dwell_state_t;

    // Returns {undecodable, nibble}; unknown patterns decode to nibble 0.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = {1'b0, 4'h0};
            7'h06:   res = {1'b0, 4'h1};
            7'h5B:   res = {1'b0, 4'h2};
            7'h4F:   res = {1'b0, 4'h3};
            7'h66:   res = {1'b0, 4'h4};
            7'h6D:   res = {1'b0, 4'h5};
            7'h7D:   res = {1'b0, 4'h6};
            7'h07:   res = {1'b0, 4'h7};
            7'h7F:   res = {1'b0, 4'h8};
            7'h6F:   res = {1'b0, 4'h9};
            7'h77:   res = {1'b0, 4'hA};
            7'h7C:   res = {1'b0, 4'hB};
            7'h39:   res = {1'b0, 4'hC};
            7'h5E:   res = {1'b0, 4'hD};
            7'h79:   res = {1'b0, 4'hE};
            7'h71:   res = {1'b0, 4'hF};
            default: res = {1'b1, 4'h0};
        endcase
        return res;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    logic [3:0]        an_r, an_prev_r;
    logic [6:0]        ds_r, ds_prev_r;
    dwell_state_t      state_r, state_nxt_s;
    logic [STAB_W-1:0] stab_cnt_r, stab_cnt_nxt_s;
    logic              settled_s;
    logic              changed_s;
    logic              onehot_s, multihot_s;
    logic              capture_s, multi_hit_s;
    logic [4:0]        dec_s;
    logic [1:0]        idx_s;
    logic [3:0][3:0]   slot_r;
    logic [3:0]        slot_vld_r, slot_bad_r;
    logic [3:0]        slot_vld_nxt_s, slot_bad_nxt_s;
    logic [3:0]        base_vld_s, base_bad_s, sel_s;
    logic              frame_done_s, any_vld_s, to_hit_s;
    logic [TO_W-1:0]   to_cnt_r;

    // Input sampling stage plus previous-cycle copy used for change detection.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            an_r      <= 4'd0;
            ds_r      <= 7'd0;
            an_prev_r <= 4'd0;
            ds_prev_r <= 7'd0;
        end else begin
            an_r      <= AN;
            ds_r      <= SEG_INV ? ~DS7 : DS7;
            an_prev_r <= an_r;
            ds_prev_r <= ds_r;
        end
    end

    assign changed_s = ({an_r, ds_r} != {an_prev_r, ds_prev_r});

    // Dwell state register.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_r    <= ST_WAIT;
            stab_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            stab_cnt_r <= stab_cnt_nxt_s;
        end
    end

    // Dwell next-state: one settle action per stable dwell.
    always_comb begin
        state_nxt_s    = state_r;
        stab_cnt_nxt_s = stab_cnt_r;
        settled_s      = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (changed_s) begin
                    state_nxt_s    = ST_SETTLE;
                    stab_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    stab_cnt_nxt_s = '0;
                end else if (stab_cnt_r == STAB_LAST) begin
                    settled_s      = 1'b1;
                    state_nxt_s    = ST_HOLD;
                    stab_cnt_nxt_s = '0;
                end else begin
                    stab_cnt_nxt_s = stab_cnt_r + STAB_W'(1);
                end
            end
            ST_HOLD: begin
                if (changed_s) begin
                    state_nxt_s    = ST_SETTLE;
                    stab_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s    = ST_WAIT;
                stab_cnt_nxt_s = '0;
            end
        endcase
    end

    assign onehot_s     = (an_r != 4'd0) && ((an_r & (an_r - 4'd1)) == 4'd0);
    assign multihot_s   = (an_r != 4'd0) && !onehot_s;
    assign capture_s    = settled_s && onehot_s;
    assign multi_hit_s  = settled_s && multihot_s;
    assign dec_s        = seg_decode(ds_r);
    assign idx_s        = onehot_idx(an_r);
    assign frame_done_s = &slot_vld_r;
    assign any_vld_s    = |slot_vld_r;
    assign to_hit_s     = any_vld_s && (to_cnt_r == TO_LAST);

    // Slot flag update; a capture beats a coincident timeout.
    always_comb begin
        sel_s          = 4'b0001 << idx_s;
        base_vld_s     = frame_done_s ? 4'd0 : slot_vld_r;
        base_bad_s     = frame_done_s ? 4'd0 : slot_bad_r;
        slot_vld_nxt_s = slot_vld_r;
        slot_bad_nxt_s = slot_bad_r;
        if (capture_s) begin
            slot_vld_nxt_s = base_vld_s | sel_s;
            slot_bad_nxt_s = (base_bad_s & ~sel_s) | (dec_s[4] ? sel_s : 4'd0);
        end else if (multi_hit_s || frame_done_s || to_hit_s) begin
            slot_vld_nxt_s = 4'd0;
            slot_bad_nxt_s = 4'd0;
        end else begin
            slot_vld_nxt_s = slot_vld_r;
            slot_bad_nxt_s = slot_bad_r;
        end
    end

    // Slot storage.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            slot_r     <= '0;
            slot_vld_r <= 4'd0;
            slot_bad_r <= 4'd0;
        end else begin
            slot_vld_r <= slot_vld_nxt_s;
            slot_bad_r <= slot_bad_nxt_s;
            if (capture_s) begin
                slot_r[idx_s] <= dec_s[3:0];
            end else begin
                slot_r <= slot_r;
            end
        end
    end

    // Partial-frame timeout counter; idle at 0 while no slot is valid.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if (capture_s || multi_hit_s || frame_done_s || !any_vld_s) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r == TO_LAST) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end
    end

    // Registered frame outputs and error pulses.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            VALUE       <= 16'd0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            an_err      <= 1'b0;
        end else begin
            frame_valid <= frame_done_s;
            an_err      <= multi_hit_s;
            if (frame_done_s) begin
                VALUE   <= slot_r;
                seg_err <= |slot_bad_r;
            end else begin
                VALUE   <= VALUE;
                seg_err <= seg_err;
            end
        end
    end

`ifdef SEG7_CAPTURE_FRAME_CNT_EN
    // Completed-frame counter, wraps naturally.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            frame_cnt <= 16'd0;
        end else if (frame_done_s) begin
            frame_cnt <= frame_cnt + 16'd1;
        end else begin
            frame_cnt <= frame_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: directed scans with literal expectations plus
// randomized scanning compared every cycle against a run-length based behavioural model.
module tb_seg7_scan_capture;
    localparam int S = 4;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  ds;
    logic [15:0] value;
    logic        frame_valid, seg_err, an_err;
`ifdef SEG7_CAPTURE_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    seg7_scan_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .SEG_INV(1'b0)) dut (
        .CLK100MHZ(clk),
        .reset(reset),
        .AN(an),
        .DS7(ds),
        .VALUE(value),
        .frame_valid(frame_valid),
        .seg_err(seg_err),
        .an_err(an_err)
`ifdef SEG7_CAPTURE_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  m_an, m_an_p;
    logic [6:0]  m_ds, m_ds_p;
    bit          m_seen, m_live;
    int          m_run, m_age;
    logic [3:0]  m_slot [4];
    bit          m_vld [4];
    bit          m_bad [4];
    logic [15:0] m_value, m_cnt;
    bit          m_fv, m_seg, m_anerr;

    always @(posedge clk) begin : model
        bit act, complete, anyv, cap, multi, badp, changed;
        int ones, idx, nib;
        if (reset) begin
            m_an = 4'd0; m_an_p = 4'd0; m_ds = 7'd0; m_ds_p = 7'd0;
            m_seen = 1'b0; m_run = 0; m_age = 0;
            for (int i = 0; i < 4; i++) begin
                m_slot[i] = 4'd0; m_vld[i] = 1'b0; m_bad[i] = 1'b0;
            end
            m_value = 16'd0; m_cnt = 16'd0; m_fv = 1'b0; m_seg = 1'b0; m_anerr = 1'b0;
            m_live = 1'b1;
        end else begin
            changed = ({m_an, m_ds} != {m_an_p, m_ds_p});
            act = 1'b0;
            if (changed) begin
                m_seen = 1'b1;
                m_run  = 0;
            end else if (m_seen && m_run <= S) begin
                m_run++;
                act = (m_run == S);
            end
            complete = m_vld[0] && m_vld[1] && m_vld[2] && m_vld[3];
            anyv     = m_vld[0] || m_vld[1] || m_vld[2] || m_vld[3];
            ones     = $countones(m_an);
            cap      = act && (ones == 1);
            multi    = act && (ones > 1);
            m_fv     = 1'b0;
            m_anerr  = multi;
            if (complete) begin
                m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                m_fv    = 1'b1;
                m_seg   = m_bad[0] || m_bad[1] || m_bad[2] || m_bad[3];
                m_cnt   = m_cnt + 16'd1;
            end
            if (cap) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (m_an[i]) idx = i;
                nib = 0; badp = 1'b1;
                for (int k = 0; k < 16; k++) if (seg_tab[k] == m_ds) begin nib = k; badp = 1'b0; end
                if (complete) for (int i = 0; i < 4; i++) begin m_vld[i] = 1'b0; m_bad[i] = 1'b0; end
                m_slot[idx] = 4'(nib); m_vld[idx] = 1'b1; m_bad[idx] = badp; m_age = 0;
            end else if (multi || complete) begin
                for (int i = 0; i < 4; i++) begin m_vld[i] = 1'b0; m_bad[i] = 1'b0; end
                m_age = 0;
            end else if (anyv) begin
                if (m_age == T - 1) begin
                    for (int i = 0; i < 4; i++) begin m_vld[i] = 1'b0; m_bad[i] = 1'b0; end
                    m_age = 0;
                end else begin
                    m_age++;
                end
            end else begin
                m_age = 0;
            end
            m_an_p = m_an; m_ds_p = m_ds;
            m_an   = an;   m_ds   = ds;
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    int          fv_count = 0;
    int          anerr_count = 0;
    logic [15:0] last_val = 16'd0;
    logic        last_seg = 1'b0;

    always @(posedge clk) begin
        #1;
        if (m_live) begin
            check("value", 32'(value), 32'(m_value));
            check("frame_valid", 32'(frame_valid), 32'(m_fv));
            check("seg_err", 32'(seg_err), 32'(m_seg));
            check("an_err", 32'(an_err), 32'(m_anerr));
`ifdef SEG7_CAPTURE_FRAME_CNT_EN
            check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
`endif
        end
        if (frame_valid === 1'b1) begin
            fv_count++;
            last_val = value;
            last_seg = seg_err;
        end
        if (an_err === 1'b1) anerr_count++;
    end

    // ---------------- stimulus ----------------
    task automatic hold(input logic [3:0] a, input logic [6:0] d, input int n);
        an = a;
        ds = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3);
        hold(4'b0001, d0, 10);
        hold(4'b0010, d1, 10);
        hold(4'b0100, d2, 10);
        hold(4'b1000, d3, 10);
        hold(4'b0000, 7'h00, 3);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        an = 4'd0;
        ds = 7'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int f0, a0, r, len;
        logic [3:0] ra;
        logic [6:0] rd;
        reset = 1'b1;
        an = 4'd0;
        ds = 7'd0;
        repeat (3) @(negedge clk);
        check("rst_value", 32'(value), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_seg", 32'(seg_err), 32'h0);
        check("rst_anerr", 32'(an_err), 32'h0);
        reset = 1'b0;

        // basic scan
        f0 = fv_count;
        scan4(7'h06, 7'h5B, 7'h4F, 7'h66);
        check("t1_frames", 32'(fv_count - f0), 32'd1);
        check("t1_value", 32'(last_val), 32'h4321);
        check("t1_seg", 32'(last_seg), 32'h0);
        hold(4'b0000, 7'h00, 80);

        // too-short dwell must not capture
        f0 = fv_count;
        hold(4'b0001, 7'h3F, 3);
        hold(4'b0010, 7'h07, 10);
        hold(4'b0100, 7'h7F, 10);
        hold(4'b1000, 7'h6F, 10);
        check("t2_no_early_frame", 32'(fv_count - f0), 32'd0);
        hold(4'b0001, 7'h06, 10);
        hold(4'b0000, 7'h00, 3);
        check("t2_frames", 32'(fv_count - f0), 32'd1);
        check("t2_value", 32'(last_val), 32'h9871);
        hold(4'b0000, 7'h00, 80);

        // undecodable digit
        f0 = fv_count;
        scan4(7'h7F, 7'h7F, 7'h55, 7'h7F);
        check("t3_frames", 32'(fv_count - f0), 32'd1);
        check("t3_value", 32'(last_val), 32'h8088);
        check("t3_seg", 32'(last_seg), 32'h1);
        hold(4'b0000, 7'h00, 80);

        // multi-hot AN
        hold(4'b0001, 7'h06, 10);
        hold(4'b0010, 7'h5B, 10);
        a0 = anerr_count;
        hold(4'b0101, 7'h7F, 10);
        check("t4_anerr", 32'(anerr_count - a0), 32'd1);
        f0 = fv_count;
        scan4(7'h71, 7'h79, 7'h5E, 7'h39);
        check("t4_frames", 32'(fv_count - f0), 32'd1);
        check("t4_value", 32'(last_val), 32'hCDEF);
        check("t4_seg", 32'(last_seg), 32'h0);
        hold(4'b0000, 7'h00, 80);

        // timeout discards partial frame
        f0 = fv_count;
        hold(4'b0001, 7'h6D, 10);
        hold(4'b0010, 7'h7D, 10);
        hold(4'b0000, 7'h00, 100);
        hold(4'b0100, 7'h07, 10);
        hold(4'b1000, 7'h7F, 10);
        hold(4'b0000, 7'h00, 3);
        check("t5_no_frame", 32'(fv_count - f0), 32'd0);
        scan4(7'h6D, 7'h7D, 7'h07, 7'h7F);
        check("t5_frames", 32'(fv_count - f0), 32'd1);
        check("t5_value", 32'(last_val), 32'h8765);
        hold(4'b0000, 7'h00, 80);

        // reset mid-frame
        hold(4'b0001, 7'h06, 10);
        hold(4'b0010, 7'h5B, 10);
        hold(4'b0100, 7'h4F, 10);
        pulse_reset();
        check("t6_value", 32'(value), 32'h0);
        check("t6_fv", 32'(frame_valid), 32'h0);
        check("t6_seg", 32'(seg_err), 32'h0);
        check("t6_anerr", 32'(an_err), 32'h0);
        f0 = fv_count;
        hold(4'b1000, 7'h66, 10);
        hold(4'b0000, 7'h00, 80);
        check("t6_no_frame", 32'(fv_count - f0), 32'd0);
        scan4(7'h06, 7'h5B, 7'h4F, 7'h66);
        check("t6_frames", 32'(fv_count - f0), 32'd1);
        check("t6_value2", 32'(last_val), 32'h4321);
`ifdef SEG7_CAPTURE_FRAME_CNT_EN
        check("t6_frame_cnt", 32'(frame_cnt), 32'd1);
`endif

        // randomized scanning against the model
        repeat (400) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                pulse_reset();
            end else if (r < 5) begin
                hold(4'b0000, 7'h00, 70);
            end else if (r < 30) begin
                for (int i = 0; i < 4; i++) begin
                    rd = ($urandom_range(0, 9) < 9) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
                    hold(4'(1 << i), rd, $urandom_range(3, 8));
                end
            end else begin
                ra  = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                rd  = ($urandom_range(0, 9) < 8) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom_range(0, 127));
                len = $urandom_range(1, 12);
                hold(ra, rd, len);
            end
        end
        hold(4'b0000, 7'h00, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
